// File: rtl/main_controller.sv
// main_controller: serial image load then per-pixel Moravec corner scoring over a 3x3 window
module main_controller #(
  parameter int N = 8,
  parameter int bitSize = $clog2(N*N),
  parameter int pixelWidth = 8,
  parameter int THRESH = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [pixelWidth-1:0] data_in,
  output logic out_valid,
  output logic [bitSize-1:0] out_addr,
  output logic [2*pixelWidth:0] out_score,
  output logic out_corner,
  output logic busy,
  output logic done
);
  localparam int SW = 2*pixelWidth+1;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, PROC = 2'd2, DONE = 2'd3;
  localparam logic [bitSize-1:0] LAST = bitSize'(N*N-1);
  logic [1:0] state;
  logic [bitSize-1:0] wr_addr, rd_pix, raddr, row, col;
  logic [3:0] k;
  logic [pixelWidth-1:0] ram [N*N];
  logic [pixelWidth-1:0] rdata;
  logic [pixelWidth-1:0] win [9];
  logic [SW-1:0] score, v_ew, v_ns, v_d1, v_d2, m_a, m_b, m_min;
  logic border;

  function automatic logic [2*pixelWidth-1:0] sq(input logic [pixelWidth-1:0] a, input logic [pixelWidth-1:0] b);
    logic signed [2*pixelWidth+1:0] d, p;
    d = (2*pixelWidth+2)'($signed({1'b0, a}) - $signed({1'b0, b}));
    p = d * d;
    return p[2*pixelWidth-1:0];
  endfunction

  function automatic logic [SW-1:0] pair(input logic [pixelWidth-1:0] c, input logic [pixelWidth-1:0] a, input logic [pixelWidth-1:0] b);
    return {1'b0, sq(c, a)} + {1'b0, sq(c, b)};
  endfunction

  // window tap k walks NW..SE around rd_pix; border pixels may wrap, their data is ignored
  assign raddr = bitSize'(int'(rd_pix) + (int'(k) / 3 - 1) * N + int'(k) % 3 - 1);
  assign row = rd_pix / bitSize'(N);
  assign col = rd_pix % bitSize'(N);
  assign border = row == '0 || row == bitSize'(N-1) || col == '0 || col == bitSize'(N-1);
  assign v_ew = pair(win[4], win[5], win[3]);
  assign v_ns = pair(win[4], win[1], win[7]);
  assign v_d1 = pair(win[4], win[0], win[8]);
  assign v_d2 = pair(win[4], win[2], win[6]);
  assign m_a = v_ew < v_ns ? v_ew : v_ns;
  assign m_b = v_d1 < v_d2 ? v_d1 : v_d2;
  assign m_min = m_a < m_b ? m_a : m_b;
  assign busy = state == PROC;
  assign done = state == DONE;

  // image RAM write port: first write of a load always lands at address 0
  always_ff @(posedge clk)
    if (we && !rst) ram[state == LOAD ? wr_addr : '0] <= data_in;

  // registered RAM read, then shift into the window slot of the previous tap
  always_ff @(posedge clk) begin
    rdata <= ram[raddr];
    if (k >= 4'd1 && k <= 4'd9) win[k - 4'd1] <= rdata;
  end

  // control FSM, phase sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_addr <= '0;
      rd_pix <= '0;
      k <= '0;
      score <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_score <= '0;
      out_corner <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (we) begin
        state <= LOAD;
        wr_addr <= state != LOAD ? bitSize'(1) : wr_addr == LAST ? '0 : wr_addr + 1'b1;
      end else if (state == LOAD) begin
        state <= PROC;
        rd_pix <= '0;
        k <= '0;
      end else if (state == PROC) begin
        if (out_valid && out_addr == LAST) state <= DONE;
        k <= k == 4'd11 ? 4'd0 : k + 4'd1;
        if (k == 4'd10) score <= border ? '0 : m_min;
        if (k == 4'd11) begin
          rd_pix <= rd_pix == LAST ? '0 : rd_pix + 1'b1;
          out_valid <= 1'b1;
          out_addr <= rd_pix;
          out_score <= score;
          out_corner <= score > SW'(THRESH);
        end
      end
    end
  end
endmodule

// File: tb/tb_main_controller.sv
// tb_main_controller: scoreboard plus table checks of the corner controller on an 8x8 image
module tb_main_controller;
  localparam int N = 8;
  localparam int NN = N*N;
  logic clk = 1'b0;
  logic rst, we;
  logic [7:0] data_in;
  logic out_valid, out_corner, busy, done;
  logic [5:0] out_addr;
  logic [16:0] out_score;

  typedef struct {int addr; int score; int corner;} exp_t;
  typedef struct {int pat; int addr; int score; int corner;} vec_t;

  int total = 0;
  int bad = 0;
  int img [NN];
  int res_score [NN];
  int res_corner [NN];
  exp_t sb [$];
  vec_t tbl [13];

  main_controller dut (
    .clk(clk), .rst(rst), .we(we), .data_in(data_in),
    .out_valid(out_valid), .out_addr(out_addr), .out_score(out_score),
    .out_corner(out_corner), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int sqd(input int a, input int b);
    return (a - b) * (a - b);
  endfunction

  function automatic int model(input int p);
    int r, c, v, ew, ns, d1, d2, m;
    r = p / N;
    c = p % N;
    if (r == 0 || c == 0 || r == N-1 || c == N-1) return 0;
    v = img[p];
    ew = sqd(v, img[p-1]) + sqd(v, img[p+1]);
    ns = sqd(v, img[p-N]) + sqd(v, img[p+N]);
    d1 = sqd(v, img[p-N-1]) + sqd(v, img[p+N+1]);
    d2 = sqd(v, img[p-N+1]) + sqd(v, img[p+N-1]);
    m = ew;
    if (ns < m) m = ns;
    if (d1 < m) m = d1;
    if (d2 < m) m = d2;
    return m;
  endfunction

  function automatic void build(input int pat);
    for (int i = 0; i < NN; i++) begin
      int r, c;
      r = i / N;
      c = i % N;
      img[i] = pat == 0 ? 50 :
               pat == 1 ? ((r == 3 && c == 3) ? 200 : 0) :
               pat == 2 ? ((r >= 4 && c >= 4) ? 100 : 0) :
               pat == 3 ? (c >= 4 ? 100 : 0) : 0;
    end
  endfunction

  task automatic load(input int extra);
    int stray;
    stray = 0;
    for (int i = 0; i < NN + extra; i++) begin
      we = 1'b1;
      data_in = i < NN ? 8'(img[i]) : 8'd200;
      tick();
      if (out_valid) stray++;
    end
    if (extra != 0) img[0] = 200;
    chk("load_no_strobe", stray, 0);
  endtask

  task automatic run_proc();
    int n, cnt, done_n;
    exp_t e;
    we = 1'b0;
    for (int p = 0; p < NN; p++) sb.push_back('{p, model(p), model(p) > 5000 ? 1 : 0});
    tick();
    chk("busy_in_proc", int'(busy), 1);
    cnt = 0;
    done_n = -1;
    for (n = 1; n < 900; n++) begin
      tick();
      if (out_valid) begin
        chk("strobe_time", n, 12 * (cnt + 1));
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_addr", int'(out_addr), e.addr);
          chk("out_score", int'(out_score), e.score);
          chk("out_corner", int'(out_corner), e.corner);
          res_score[out_addr] = int'(out_score);
          res_corner[out_addr] = int'(out_corner);
        end
        cnt++;
      end
      if (done) begin
        done_n = n;
        break;
      end
    end
    chk("strobe_count", cnt, NN);
    chk("done_time", done_n, 769);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int cnt;
    tbl[0]  = '{0, 27, 0, 0};
    tbl[1]  = '{1, 27, 80000, 1};
    tbl[2]  = '{1, 26, 0, 0};
    tbl[3]  = '{1, 28, 0, 0};
    tbl[4]  = '{2, 36, 10000, 1};
    tbl[5]  = '{2, 37, 0, 0};
    tbl[6]  = '{2, 0, 0, 0};
    tbl[7]  = '{2, 3, 0, 0};
    tbl[8]  = '{2, 7, 0, 0};
    tbl[9]  = '{3, 35, 0, 0};
    tbl[10] = '{3, 36, 0, 0};
    tbl[11] = '{4, 9, 0, 0};
    tbl[12] = '{4, 0, 0, 0};
    rst = 1'b1;
    we = 1'b0;
    data_in = '0;
    tick();
    tick();
    chk("reset_outputs", int'({out_valid, out_addr, out_score, out_corner, busy, done}), 0);
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      build(p);
      load(p == 4 ? 1 : 0);
      run_proc();
      for (int i = 0; i < 13; i++)
        if (tbl[i].pat == p) begin
          chk($sformatf("tbl%0d_score", i), res_score[tbl[i].addr], tbl[i].score);
          chk($sformatf("tbl%0d_corner", i), res_corner[tbl[i].addr], tbl[i].corner);
        end
    end
    build(1);
    load(0);
    we = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("pre_abort_strobes", cnt, 2);
    load(0);
    run_proc();
    chk("abort_reload_27", res_score[27], 80000);
    build(0);
    load(0);
    we = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    we = 1'b1;
    data_in = 8'd77;
    tick();
    chk("mid_rst_outputs", int'({out_valid, out_addr, out_score, out_corner, busy, done}), 0);
    rst = 1'b0;
    we = 1'b0;
    tick();
    tick();
    chk("rst_over_we_idle", int'({busy, done, out_valid}), 0);
    build(2);
    load(0);
    run_proc();
    chk("after_rst_36", res_score[36], 10000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
